// File: rtl/nios_system_debug_slave_cmd_bridge_if.sv
// Command-bridge bus: JTAG-side strobes and shift data in, buffered command stream out.
interface nios_system_debug_slave_cmd_bridge_if #(
  parameter int unsigned DATA_W     = 38,
  parameter int unsigned IR_W       = 2,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned NCH   = 1 << IR_W;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              vs_uir;
  logic              vs_udr;
  logic [IR_W-1:0]   ir_in;
  logic [DATA_W-1:0] sr;
  logic              cmd_ready;
  logic              ovf_clr;
  logic              cmd_valid;
  logic [DATA_W-1:0] cmd_data;
  logic [IR_W-1:0]   cmd_ir;
  logic [NCH-1:0]    take_action;
  logic [NCH-1:0]    take_no_action;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;

  modport slave (
    input  vs_uir, vs_udr, ir_in, sr, cmd_ready, ovf_clr,
    output cmd_valid, cmd_data, cmd_ir, take_action, take_no_action, fifo_level, overflow
  );

  modport master (
    output vs_uir, vs_udr, ir_in, sr, cmd_ready, ovf_clr,
    input  cmd_valid, cmd_data, cmd_ir, take_action, take_no_action, fifo_level, overflow
  );
endinterface

// File: rtl/nios_system_debug_slave_cmd_bridge.sv
// Moves JTAG update-IR/update-DR strobes into the clk domain and queues {ir, sr}
// commands in a small FIFO, decoding them into one-hot take pulses on pop.
module nios_system_debug_slave_cmd_bridge #(
  parameter int unsigned DATA_W      = 38,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic clk,
  input  logic reset,
  nios_system_debug_slave_cmd_bridge_if.slave bus
);
  localparam int unsigned NCH   = 1 << IR_W;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = AW + 1;
  localparam int unsigned ENT_W = IR_W + DATA_W;

  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic                   uir_hist;
  logic                   udr_hist;
  logic                   uir_edge;
  logic                   udr_edge;

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [IR_W-1:0]   ir_q;
  logic              ovf;
  logic [ENT_W-1:0]  head;
  logic [IR_W-1:0]   head_ir;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [NCH-1:0]    take_act;
  logic [NCH-1:0]    take_noact;

  // Flops preset to 1 so a strobe already high at reset release is not seen as a new edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      uir_sync <= '1;
      udr_sync <= '1;
      uir_hist <= 1'b1;
      udr_hist <= 1'b1;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
      uir_hist <= uir_sync[SYNC_STAGES-1];
      udr_hist <= udr_sync[SYNC_STAGES-1];
    end
  end

  assign uir_edge = uir_sync[SYNC_STAGES-1] & ~uir_hist;
  assign udr_edge = udr_sync[SYNC_STAGES-1] & ~udr_hist;

  assign head    = mem[rd_ptr];
  assign head_ir = head[ENT_W-1:DATA_W];
  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign pop     = (level != '0) & bus.cmd_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push    = udr_edge & (~full | pop);
  assign drop    = udr_edge & full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (uir_edge) ir_q <= bus.ir_in;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop)             ovf <= 1'b1;
      else if (bus.ovf_clr) ovf <= 1'b0;
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ir_q, bus.sr};
  end

  always_comb begin
    take_act   = '0;
    take_noact = '0;
    if (pop) begin
      if (head[DATA_W-1]) take_act[head_ir]   = 1'b1;
      else                take_noact[head_ir] = 1'b1;
    end
  end

  assign bus.cmd_valid      = (level != '0);
  assign bus.cmd_data       = head[DATA_W-1:0];
  assign bus.cmd_ir         = head_ir;
  assign bus.fifo_level     = level;
  assign bus.overflow       = ovf;
  assign bus.take_action    = take_act;
  assign bus.take_no_action = take_noact;

endmodule

// File: tb/tb_nios_system_debug_slave_cmd_bridge.sv
// Bench for the debug command bridge: directed scenarios plus random strobes,
// every cycle compared against a queue-based reference model.
module tb_nios_system_debug_slave_cmd_bridge;
  localparam int unsigned DATA_W      = 38;
  localparam int unsigned IR_W        = 2;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned NCH         = 1 << IR_W;

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nios_system_debug_slave_cmd_bridge_if #(
    .DATA_W(DATA_W), .IR_W(IR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) bus ();

  nios_system_debug_slave_cmd_bridge #(
    .DATA_W(DATA_W), .IR_W(IR_W), .SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Values applied at the next negedge
  logic              d_reset, d_uir, d_udr, d_ready, d_clr;
  logic [IR_W-1:0]   d_ir;
  logic [DATA_W-1:0] d_sr;

  // Reference model: command queue, channel register, sticky flag, and pending
  // strobe edges keyed by the cycle at which they take effect.
  ent_t            q[$];
  logic [IR_W-1:0] m_ir;
  bit              m_ovf;
  int              udr_due[$];
  int              uir_due[$];
  bit              udr_prev, uir_prev;
  bit              armed;
  int              cyc;

  // Output snapshot of the latest step
  logic              s_valid, s_ovf;
  logic [DATA_W-1:0] s_data;
  logic [IR_W-1:0]   s_ir;
  logic [NCH-1:0]    s_ta, s_tn;
  logic [3:0]        s_level;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] ta, tn;
    bit v;
    ta = '0;
    tn = '0;
    v  = (q.size() != 0);
    chk("valid", 64'(bus.cmd_valid), 64'(v));
    chk("level", 64'(bus.fifo_level), 64'(q.size()));
    chk("ovf", 64'(bus.overflow), 64'(m_ovf));
    if (v) begin
      chk("data", 64'(bus.cmd_data), 64'(q[0].data));
      chk("ir", 64'(bus.cmd_ir), 64'(q[0].ir));
      if (bus.cmd_ready) begin
        if (q[0].data[DATA_W-1]) ta[q[0].ir] = 1'b1;
        else                     tn[q[0].ir] = 1'b1;
      end
    end
    chk("take_act", 64'(bus.take_action), 64'(ta));
    chk("take_noact", 64'(bus.take_no_action), 64'(tn));
  endtask

  task automatic model_edge();
    bit pop, full, do_push, do_ir, drop;
    if (reset) begin
      q.delete();
      udr_due.delete();
      uir_due.delete();
      m_ovf    = 1'b0;
      m_ir     = '0;
      udr_prev = 1'b1;
      uir_prev = 1'b1;
      armed    = 1'b1;
      return;
    end
    full    = (q.size() == FIFO_DEPTH);
    pop     = (q.size() != 0) && bus.cmd_ready;
    do_push = (udr_due.size() != 0) && (udr_due[0] == cyc);
    do_ir   = (uir_due.size() != 0) && (uir_due[0] == cyc);
    if (do_push) void'(udr_due.pop_front());
    if (do_ir)   void'(uir_due.pop_front());
    // A new high level seen now becomes a strobe edge SYNC_STAGES cycles later
    if (bus.vs_udr && !udr_prev) udr_due.push_back(cyc + SYNC_STAGES);
    if (bus.vs_uir && !uir_prev) uir_due.push_back(cyc + SYNC_STAGES);
    udr_prev = bus.vs_udr;
    uir_prev = bus.vs_uir;
    drop = 1'b0;
    if (pop) void'(q.pop_front());
    if (do_push) begin
      if (!full || pop) q.push_back('{ir: m_ir, data: bus.sr});
      else              drop = 1'b1;
    end
    if (drop)             m_ovf = 1'b1;
    else if (bus.ovf_clr) m_ovf = 1'b0;
    if (do_ir) m_ir = bus.ir_in;
  endtask

  task automatic step();
    @(negedge clk);
    reset         = d_reset;
    bus.vs_uir    = d_uir;
    bus.vs_udr    = d_udr;
    bus.ir_in     = d_ir;
    bus.sr        = d_sr;
    bus.cmd_ready = d_ready;
    bus.ovf_clr   = d_clr;
    #1;
    s_valid = bus.cmd_valid;
    s_ovf   = bus.overflow;
    s_data  = bus.cmd_data;
    s_ir    = bus.cmd_ir;
    s_ta    = bus.take_action;
    s_tn    = bus.take_no_action;
    s_level = 4'(bus.fifo_level);
    if (armed) check_outputs();
    model_edge();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    d_reset = 1'b1;
    run(2);
    d_reset = 1'b0;
    run(1);
    chk("rst_valid", 64'(s_valid), 64'(0));
    chk("rst_level", 64'(s_level), 64'(0));
    chk("rst_ovf", 64'(s_ovf), 64'(0));
    chk("rst_take", 64'({s_ta, s_tn}), 64'(0));
  endtask

  task automatic udr_pulse(input logic [DATA_W-1:0] val);
    d_sr  = val;
    d_udr = 1'b1;
    run(3);
    d_udr = 1'b0;
    run(3);
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    cyc = 0;
    armed = 1'b0;
    d_reset = 1'b1; d_uir = 1'b0; d_udr = 1'b0; d_ready = 1'b0; d_clr = 1'b0;
    d_ir = '0; d_sr = '0;

    // Action command on channel 2, popped SYNC_STAGES+1 cycles after udr is sampled
    do_reset();
    d_uir = 1'b1; d_ir = 2'd2; run(4);
    d_uir = 1'b0; run(4);
    d_sr = 38'h20_0000_00AB; d_ready = 1'b1; d_udr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 2) chk("act_early", 64'(s_ta), 64'(0));
      if (i == 3) begin
        chk("act_onehot", 64'(s_ta), 64'(4'b0100));
        chk("act_data", 64'(s_data), 64'(38'h20_0000_00AB));
      end
      if (i == 4) chk("act_once", 64'(s_ta), 64'(0));
    end
    d_udr = 1'b0; run(3);

    // Overflow: six pushes into a 4-deep FIFO, then ordered drain and clear
    d_ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      v = DATA_W'(p + 1);
      v[DATA_W-1] = p[0];
      udr_pulse(v);
    end
    chk("ovf_level", 64'(s_level), 64'(4));
    chk("ovf_set", 64'(s_ovf), 64'(1));
    d_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      step();
      v = DATA_W'(p + 1);
      v[DATA_W-1] = p[0];
      chk("drain_order", 64'(s_data), 64'(v));
    end
    d_ready = 1'b0; d_clr = 1'b1; run(1);
    d_clr = 1'b0; run(1);
    chk("ovf_clr", 64'(s_ovf), 64'(0));

    // Push coinciding with a pop while full is accepted
    for (int p = 0; p < 4; p++) udr_pulse(DATA_W'(p + 16));
    d_sr = DATA_W'(99); d_udr = 1'b1; run(2);
    d_ready = 1'b1; run(1);
    d_ready = 1'b0; d_udr = 1'b0; run(2);
    chk("full_pp_level", 64'(s_level), 64'(4));
    chk("full_pp_ovf", 64'(s_ovf), 64'(0));
    d_ready = 1'b1; run(6); d_ready = 1'b0;

    // Long udr level yields one push
    d_sr = DATA_W'(7); d_udr = 1'b1; run(50);
    d_udr = 1'b0; run(3);
    chk("long_level", 64'(s_level), 64'(1));
    d_ready = 1'b1; run(2); d_ready = 1'b0;

    // udr held through reset release, then reset with queued and in-flight commands
    d_udr = 1'b1; d_reset = 1'b1; run(3);
    d_reset = 1'b0; run(10);
    chk("hold_rst_level", 64'(s_level), 64'(0));
    d_udr = 1'b0; run(2);
    for (int p = 0; p < 3; p++) udr_pulse(DATA_W'(p + 40));
    chk("queued3", 64'(s_level), 64'(3));
    d_udr = 1'b1; run(1);
    d_reset = 1'b1; run(1);
    d_reset = 1'b0; d_udr = 1'b0; run(4);
    chk("mid_rst_level", 64'(s_level), 64'(0));
    chk("mid_rst_valid", 64'(s_valid), 64'(0));

    // Coincident uir/udr edges push with the previous channel
    do_reset();
    d_uir = 1'b1; d_ir = 2'd1; run(3);
    d_uir = 1'b0; run(3);
    d_ir = 2'd3; d_uir = 1'b1; d_udr = 1'b1; d_sr = DATA_W'(5); run(3);
    d_uir = 1'b0; d_udr = 1'b0; run(3);
    udr_pulse(DATA_W'(6));
    chk("coin_level", 64'(s_level), 64'(2));
    d_ready = 1'b1;
    step(); chk("coin_ir_old", 64'(s_ir), 64'(1));
    step(); chk("coin_ir_new", 64'(s_ir), 64'(3));
    d_ready = 1'b0; run(2);

    // Random strobes, consumer stalls, clears and occasional resets
    for (int i = 0; i < 3000; i++) begin
      d_reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) d_udr = ~d_udr;
      if ($urandom_range(0, 5) == 0) d_uir = ~d_uir;
      if (!d_uir) d_ir = IR_W'($urandom);
      if (!d_udr) d_sr = {DATA_W'($urandom), 6'($urandom)} >> 6 | (DATA_W'($urandom_range(0, 1)) << (DATA_W - 1));
      d_ready = ($urandom_range(0, 2) == 0);
      d_clr   = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
